gcd_scheduler: RTL and testbench
================================

# gcd_scheduler

Shares one GCD engine between `NUM_REQ` independent requesters. Each requester gets a valid/ready request port. The block arbitrates round-robin, sequences the engine's single-cycle start and done pulses, and returns a tagged result on a shared valid/ready response port. Zero-operand requests bypass the engine, and a watchdog recovers from an engine that never signals done.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `W`, 32, operand/result width
- `TIMEOUT`, 1024, max cycles in WAIT before the error response (≥ 4)
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `req_valid` in NUM_REQ: per-requester request valid
- `req_ready` out NUM_REQ: per-requester accept, one-hot or zero
- `req_a` in NUM_REQ×W: packed operand a per requester
- `req_b` in NUM_REQ×W: packed operand b per requester
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: response consumer ready
- `rsp_id` out $clog2(NUM_REQ): index of the requester being answered
- `rsp_result` out W: GCD, or 0 on error
- `rsp_err` out 1: response produced by timeout
- `eng_start` out 1: one-cycle engine start pulse
- `eng_a`, `eng_b` out W: operands, valid in the `eng_start` cycle
- `eng_result` in W: engine result, sampled when `eng_done`=1
- `eng_done` in 1: one-cycle engine done pulse

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant the first requester with `req_valid` at or after `rr_ptr`, searching upward with wrap.
  - `req_ready[grant]`=1 combinationally. This is the accept cycle.
  - Latch a, b and id. Set `rr_ptr` ← grant+1 mod NUM_REQ.
- Zero bypass at acceptance:
  - If a==0 or b==0, skip the engine and go to RESP. Result = a|b, so gcd(0,x)=x and gcd(0,0)=0.
  - Otherwise go to ISSUE.
- ISSUE: `eng_start`=1 for exactly one cycle with the latched operands, then go to WAIT. Clear the watchdog counter.
- WAIT:
  - On `eng_done`: capture `eng_result`, set `rsp_err`=0, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT−1: set `rsp_result`=0 and `rsp_err`=1, go to RESP.
  - If `eng_done` and the timeout hit in the same cycle, done wins and `rsp_err`=0.
- RESP: `rsp_valid`=1. `rsp_id`, `rsp_result` and `rsp_err` are stable until `rsp_valid`&&`rsp_ready`, then go to IDLE.
- `eng_done` outside WAIT is ignored, including a late done from a timed-out job.
- No requests are accepted outside IDLE; `req_ready`=0 in all other states.
- Zero-width width rule: a==0 and b==0 are the only special cases. All other values go to the engine unchanged.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_err`=0, `eng_start`=0, `eng_a`=0, `eng_b`=0, counter 0.
- Accept at cycle T → `eng_start` at T+1 → WAIT from T+2.
- `eng_done` at cycle D → `rsp_valid` at D+1.
- Bypass accept at T → `rsp_valid` at T+1.
- Back-to-back: a response handshake at R allows the next accept at R+1 (IDLE lasts at least one cycle).
- Reset mid-operation: everything returns to the reset values immediately. The pending job is dropped with no response. Engine state is not touched.
- Fairness: a continuously asserted `req_valid` is granted within NUM_REQ jobs.

## Structure
- `gcd_pkg` holds:
  - the `sched_state_t` enum (IDLE, ISSUE, WAIT, RESP)
  - the `GCD_W` default constant
  - the `ID_W` function (`$clog2` with a minimum of 1)
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ.
  - Inputs: `req`, `ptr`. Outputs: one-hot `grant`, `grant_idx`, `any`.
  - Purely combinational. The scheduler owns `rr_ptr`.
- The scheduler contains the FSM, the operand/id/result registers and the watchdog counter ($clog2(TIMEOUT) bits).

## Test plan
- Single request, requester 1 with a=12, b=18; engine model returns 6 with done 5 cycles after start → `eng_start` at T+1 with 12/18; response id=1, result=6, err=0.
- All four requesters held valid with distinct operands → grants in order 0,1,2,3,0. `rr_ptr` wraps, and no requester is granted twice before every waiting one is served.
- Requester 2 with a=0, b=35 → no `eng_start`; `rsp_valid` at T+1 with id=2, result=35. Then a=0, b=0 → result 0.
- Engine model never asserts done, TIMEOUT=16 → response err=1, result=0 after 16 WAIT cycles. A late `eng_done` afterwards is ignored, and the next job completes correctly.
- `rsp_ready` held low for 10 cycles during RESP → response fields stable, `req_ready`=0 throughout; accept resumes at the cycle after the handshake.
- `reset_n` dropped in WAIT → `rsp_valid`, `eng_start` and `req_ready` read 0 immediately; after release, the first accept goes to requester 0.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD scheduler and its round-robin arbiter.
package gcd_pkg;

    // Scheduler FSM encoding, also driven out on the debug state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // Default operand/result width.
    localparam int GCD_W = 32;

    // Width of a requester index; never narrower than one bit.
    function automatic int ID_W(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/gcd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// after ptr, searching upward and wrapping. The caller owns the pointer.
module rr_arbiter
    import gcd_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = ID_W(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0] idx;

    // Walk the requesters starting at ptr and keep the first one found.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one GCD engine between NUM_REQ requesters. Requests are taken
// round-robin in IDLE, zero operands are answered without the engine, and a
// watchdog turns a silent engine into an error response.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A requester holds req_valid and its operands until it sees
// req_ready; the response holds rsp_valid, rsp_id, rsp_result and rsp_err
// unchanged until rsp_ready is seen with it.
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  W       = GCD_W,
    parameter int  TIMEOUT = 1024,
    localparam int IDW     = ID_W(NUM_REQ),
    localparam int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_result,
    output logic                 rsp_err,
    output logic                 eng_start,
    output logic [W-1:0]         eng_a,
    output logic [W-1:0]         eng_b,
    input  logic [W-1:0]         eng_result,
    input  logic                 eng_done,
    output sched_state_t         dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    sched_state_t     state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDW-1:0]   id_q;
    logic [W-1:0]     result_q;
    logic             err_q;
    logic             rsp_valid_q;
    logic             eng_start_q;
    logic [CNT_W-1:0] cnt_q;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               grant_any;
    logic [W-1:0]       sel_a;
    logic [W-1:0]       sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Operands of the granted requester and the pointer that follows it.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
        ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end

    // Accept only in IDLE; reset forces ready low even while requests are held.
    assign req_ready  = (reset_n && state_q == IDLE) ? grant : '0;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign eng_start  = eng_start_q;
    assign eng_a      = a_q;
    assign eng_b      = b_q;
    assign dbg_state  = state_q;

    // Scheduler FSM with registered response, engine start and watchdog.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            eng_start_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        id_q  <= grant_idx;
                        ptr_q <= ptr_d;
                        // gcd(0,x)=x and gcd(0,0)=0, so a|b is the answer.
                        if (sel_a == '0 || sel_b == '0) begin
                            result_q    <= sel_a | sel_b;
                            err_q       <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            eng_start_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    eng_start_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last watchdog cycle still wins.
                    if (eng_done) begin
                        result_q    <= eng_result;
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == CNT_MAX) begin
                        result_q    <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler with a small engine model.
module tb_gcd_scheduler;
    import gcd_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    logic                 clk;
    logic                 reset_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [W-1:0]         rsp_result;
    logic                 rsp_err;
    logic                 eng_start;
    logic [W-1:0]         eng_a;
    logic [W-1:0]         eng_b;
    logic [W-1:0]         eng_result;
    logic                 eng_done;
    sched_state_t         dbg_state;

    int n_vec;
    int n_fail;
    int n_starts;

    // engine model controls: mode 0 answers after eng_lat cycles, mode 1 stays silent
    int          eng_mode;
    int          eng_lat;
    int          eng_cnt;
    bit          late_req;
    logic [W-1:0] la;
    logic [W-1:0] lb;

    logic [W-1:0] exp_q[$];

    gcd_scheduler #(
        .NUM_REQ (NUM_REQ),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_result (eng_result),
        .eng_done   (eng_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, exp finish");
        $fatal(1);
    end

    function automatic logic [W-1:0] model_gcd(input logic [W-1:0] x_in, input logic [W-1:0] y_in);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = x_in;
        y = y_in;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // engine model, acting on the falling edge
    initial begin
        eng_done   = 1'b0;
        eng_result = '0;
        eng_cnt    = 0;
        la         = '0;
        lb         = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (late_req) begin
                eng_done = 1'b1;
                late_req = 1'b0;
            end
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done   = 1'b1;
                    eng_result = model_gcd(la, lb);
                end
            end
            if (eng_start === 1'b1 && eng_mode == 0) begin
                eng_cnt = eng_lat;
                la      = eng_a;
                lb      = eng_b;
            end
        end
    end

    initial begin
        n_starts = 0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) n_starts++;
        end
    end

    // driver tasks
    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    task automatic clear_req();
        req_valid = '0;
    endtask

    task automatic wait_rsp(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rsp_valid !== 1'b1 && cyc < max_cyc);
    endtask

    task automatic wait_grant(input int max_cyc);
        int cyc;
        cyc = 0;
        while (req_ready === '0 && cyc < max_cyc) begin
            @(negedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        n_vec++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d exp 0", rsp_id); end
        n_vec++; if (rsp_result !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_result: got %0d exp 0", rsp_result); end
        n_vec++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b exp 0", rsp_err); end
        n_vec++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL reset_eng_start: got %b exp 0", eng_start); end
        n_vec++; if (eng_a !== 32'd0 || eng_b !== 32'd0) begin n_fail++; $display("FAIL reset_eng_ops: got %0d/%0d exp 0/0", eng_a, eng_b); end
        n_vec++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0]   exp_id[5];
        logic [W-1:0] exp_r;
        int           cyc;
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd4);
        eng_mode = 0;
        eng_lat  = 3;
        set_req(0, 32'd8,  32'd12);
        set_req(1, 32'd9,  32'd6);
        set_req(2, 32'd35, 32'd14);
        set_req(3, 32'd17, 32'd5);
        #1;
        for (int j = 0; j < 5; j++) begin
            wait_grant(20);
            n_vec++; if (req_ready !== (4'b0001 << exp_id[j])) begin n_fail++; $display("FAIL rr_grant%0d: got %b exp %b", j, req_ready, 4'b0001 << exp_id[j]); end
            wait_rsp(30, cyc);
            exp_r = exp_q.pop_front();
            n_vec++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_rsp_valid%0d: got %b exp 1", j, rsp_valid); end
            n_vec++; if (rsp_id !== exp_id[j] || rsp_result !== exp_r || rsp_err !== 1'b0) begin
                n_fail++; $display("FAIL rr_rsp%0d: got id %0d res %0d err %b exp id %0d res %0d err 0", j, rsp_id, rsp_result, rsp_err, exp_id[j], exp_r);
            end
            if (j == 4) clear_req();
        end
    endtask

    task automatic test_single();
        int cyc;
        eng_mode = 0;
        eng_lat  = 5;
        @(negedge clk);
        set_req(1, 32'd12, 32'd18);
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b exp 0010", req_ready); end
        @(negedge clk);
        clear_req();
        n_vec++; if (eng_start !== 1'b1 || eng_a !== 32'd12 || eng_b !== 32'd18) begin
            n_fail++; $display("FAIL single_start: got %b %0d/%0d exp 1 12/18", eng_start, eng_a, eng_b);
        end
        n_vec++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_busy_ready: got %b exp 0000", req_ready); end
        @(negedge clk);
        n_vec++; if (eng_start !== 1'b0 || dbg_state !== WAIT) begin n_fail++; $display("FAIL single_wait: got start %b state %0d exp 0 2", eng_start, dbg_state); end
        wait_rsp(30, cyc);
        n_vec++; if (cyc !== 5) begin n_fail++; $display("FAIL single_latency: got %0d exp 5", cyc); end
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'd6 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp: got v %b id %0d res %0d err %b exp 1 1 6 0", rsp_valid, rsp_id, rsp_result, rsp_err);
        end
    endtask

    task automatic test_bypass();
        int starts0;
        @(negedge clk);
        starts0 = n_starts;
        set_req(2, 32'd0, 32'd35);
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL byp_ready: got %b exp 0100", req_ready); end
        @(negedge clk);
        clear_req();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'd35 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL byp_rsp35: got v %b id %0d res %0d err %b exp 1 2 35 0", rsp_valid, rsp_id, rsp_result, rsp_err);
        end
        n_vec++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL byp_start: got %b exp 0", eng_start); end
        @(negedge clk);
        set_req(2, 32'd0, 32'd0);
        @(negedge clk);
        clear_req();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'd0) begin
            n_fail++; $display("FAIL byp_rsp0: got v %b id %0d res %0d exp 1 2 0", rsp_valid, rsp_id, rsp_result);
        end
        @(negedge clk);
        set_req(3, 32'd21, 32'd0);
        @(negedge clk);
        clear_req();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 32'd21) begin
            n_fail++; $display("FAIL byp_rsp21: got v %b id %0d res %0d exp 1 3 21", rsp_valid, rsp_id, rsp_result);
        end
        @(negedge clk);
        n_vec++; if (n_starts !== starts0) begin n_fail++; $display("FAIL byp_no_start: got %0d exp %0d", n_starts, starts0); end
    endtask

    task automatic test_timeout();
        int cyc;
        eng_mode = 1;
        set_req(0, 32'd10, 32'd4);
        @(negedge clk);
        clear_req();
        wait_rsp(40, cyc);
        n_vec++; if (cyc !== 17) begin n_fail++; $display("FAIL to_latency: got %0d exp 17", cyc); end
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd0 || rsp_err !== 1'b1) begin
            n_fail++; $display("FAIL to_rsp: got v %b id %0d res %0d err %b exp 1 0 0 1", rsp_valid, rsp_id, rsp_result, rsp_err);
        end
        @(negedge clk);
        late_req = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (rsp_valid !== 1'b0 || dbg_state !== IDLE || eng_start !== 1'b0) begin
            n_fail++; $display("FAIL to_late_done: got v %b state %0d start %b exp 0 0 0", rsp_valid, dbg_state, eng_start);
        end
        eng_mode = 0;
        eng_lat  = 4;
        set_req(3, 32'd48, 32'd36);
        @(negedge clk);
        clear_req();
        wait_rsp(30, cyc);
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 32'd12 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL to_next_rsp: got v %b id %0d res %0d err %b exp 1 3 12 0", rsp_valid, rsp_id, rsp_result, rsp_err);
        end
    endtask

    task automatic test_done_at_limit();
        int cyc;
        eng_mode = 0;
        eng_lat  = 16;
        @(negedge clk);
        set_req(1, 32'd27, 32'd18);
        @(negedge clk);
        clear_req();
        wait_rsp(40, cyc);
        n_vec++; if (cyc !== 17) begin n_fail++; $display("FAIL lim_latency: got %0d exp 17", cyc); end
        n_vec++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd9 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL lim_done_wins: got v %b res %0d err %b exp 1 9 0", rsp_valid, rsp_result, rsp_err);
        end
        eng_lat = 17;
        @(negedge clk);
        set_req(2, 32'd27, 32'd18);
        @(negedge clk);
        clear_req();
        wait_rsp(40, cyc);
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'd0 || rsp_err !== 1'b1) begin
            n_fail++; $display("FAIL lim_one_late: got v %b id %0d res %0d err %b exp 1 2 0 1", rsp_valid, rsp_id, rsp_result, rsp_err);
        end
        @(negedge clk);
        n_vec++; if (rsp_valid !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++; $display("FAIL lim_after: got v %b state %0d exp 0 0", rsp_valid, dbg_state);
        end
    endtask

    task automatic test_rsp_hold();
        int cyc;
        eng_mode  = 0;
        eng_lat   = 2;
        rsp_ready = 1'b0;
        set_req(1, 32'd21, 32'd14);
        @(negedge clk);
        clear_req();
        set_req(2, 32'd5, 32'd0);
        wait_rsp(30, cyc);
        for (int k = 0; k < 10; k++) begin
            n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'd7 || rsp_err !== 1'b0 || req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL hold_cyc%0d: got v %b id %0d res %0d err %b rdy %b exp 1 1 7 0 0000", k, rsp_valid, rsp_id, rsp_result, rsp_err, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL hold_resume: got %b exp 0100", req_ready); end
        @(negedge clk);
        clear_req();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'd5) begin
            n_fail++; $display("FAIL hold_next_rsp: got v %b id %0d res %0d exp 1 2 5", rsp_valid, rsp_id, rsp_result);
        end
    endtask

    task automatic test_reset_mid();
        eng_mode = 1;
        @(negedge clk);
        set_req(2, 32'd9, 32'd6);
        @(negedge clk);
        clear_req();
        repeat (4) @(negedge clk);
        n_vec++; if (dbg_state !== WAIT) begin n_fail++; $display("FAIL rmid_in_wait: got %0d exp 2", dbg_state); end
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'd0, 32'(i + 1));
        reset_n = 1'b0;
        #1;
        n_vec++; if (rsp_valid !== 1'b0 || eng_start !== 1'b0 || req_ready !== 4'b0000 || dbg_state !== IDLE) begin
            n_fail++; $display("FAIL rmid_reset: got v %b start %b rdy %b state %0d exp 0 0 0000 0", rsp_valid, eng_start, req_ready, dbg_state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_first_grant: got %b exp 0001", req_ready); end
        @(negedge clk);
        clear_req();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd1) begin
            n_fail++; $display("FAIL rmid_rsp: got v %b id %0d res %0d exp 1 0 1", rsp_valid, rsp_id, rsp_result);
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        eng_mode = 0;
        eng_lat  = 5;
        late_req = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_bypass();
        test_timeout();
        test_done_at_limit();
        test_rsp_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
